// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the external SRAM bank master: state encoding,
// bank geometry and small combinational helpers used by the sequencer.
package sram_ctrl_pkg;

   localparam int SRAM_AW    = 21;
   localparam int SRAM_DW    = 8;
   localparam int SRAM_CHIPS = 4;

   localparam int ST_W = 3;

   typedef enum logic [ST_W-1:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      HOLD   = 3'd3,
      ACK    = 3'd4
   } state_t;

   // Active-low one-hot chip select for a 2-bit chip number.
   function automatic logic [SRAM_CHIPS-1:0] cs_decode(input logic [1:0] sel);
      logic [SRAM_CHIPS-1:0] one;
      one = SRAM_CHIPS'(1);
      return ~(one << sel);
   endfunction

   // Lowest enabled byte lane at or above 'start'.
   // Result is {found, lane}; found = 0 when no lane remains.
   function automatic logic [2:0] first_enabled(input logic [3:0] be,
                                                input logic [2:0] start);
      logic [2:0] res;
      res = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (be[i] && (3'(i) >= start)) res = {1'b1, 2'(i)};
      end
      return res;
   endfunction

   // Byte lane 'idx' of a little-endian 32-bit word.
   function automatic logic [SRAM_DW-1:0] sel_byte(input logic [31:0] word,
                                                   input logic [1:0]  idx);
      return word[{idx, 3'b000} +: SRAM_DW];
   endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Bus-side master for the 4 x 2Mx8 asynchronous SRAM bank. A single 32-bit
// word request is split into byte accesses, each one a SETUP / STROBE / HOLD
// sequence on the shared SRAM strobes. Every output comes straight from a
// register so the pads see glitch-free strobes and chip selects.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int READ_WAIT  = 2,
   parameter int WRITE_WAIT = 2
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_req,
   input  logic                  i_we,
   input  logic [22:0]           i_addr,
   input  logic [31:0]           i_wdata,
   input  logic [3:0]            i_be,
   output logic                  o_ack,
   output logic [31:0]           o_rdata,
   output logic                  o_busy,
   output logic [SRAM_CHIPS-1:0] o_sram_cs_n,
   output logic                  o_sram_read_n,
   output logic                  o_sram_write_n,
   output logic [SRAM_AW-1:0]    o_sram_addr,
   output logic [SRAM_DW-1:0]    o_sram_data,
   output logic                  o_sram_data_oe,
   input  logic [SRAM_DW-1:0]    i_sram_data
);

   localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
   localparam int CNT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_WAIT - 1);
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_WAIT - 1);

   // Sequencer state and the latched request.
   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [1:0]            r_idx;
   logic [18:0]           r_waddr;     // word address within the chip, addr[20:2]
   logic                  r_we;
   logic [31:0]           r_wdata;
   logic [3:0]            r_be;

   // Registered outputs.
   logic                  r_ack;
   logic [31:0]           r_rdata;
   logic                  r_busy;
   logic [SRAM_CHIPS-1:0] r_cs_n;
   logic                  r_read_n;
   logic                  r_write_n;
   logic [SRAM_AW-1:0]    r_sram_addr;
   logic [SRAM_DW-1:0]    r_sram_data;
   logic                  r_oe;

   // Byte-lane selection.
   logic [2:0]            w_first;      // first enabled lane of the incoming request
   logic [1:0]            w_start_idx;  // lane of the first byte access
   logic [2:0]            w_next;       // next enabled write lane above r_idx
   logic                  w_more;       // another byte access follows this one
   logic [1:0]            w_next_idx;
   logic                  w_last_strobe;
   logic [1:0]            w_unused_addr_lsb;

   // Address bits [1:0] are word-aligned away and never looked at.
   assign w_unused_addr_lsb = i_addr[1:0];

   assign w_first     = first_enabled(i_be, 3'd0);
   assign w_start_idx = i_we ? w_first[1:0] : 2'd0;
   assign w_next      = first_enabled(r_be, {1'b0, r_idx} + 3'd1);

   // Reads walk all four lanes; writes skip to the next enabled lane.
   always_comb begin
      w_more     = 1'b0;
      w_next_idx = 2'd0;
      if (r_we) begin
         w_more     = w_next[2];
         w_next_idx = w_next[1:0];
      end else begin
         w_more     = (r_idx != 2'd3);
         w_next_idx = r_idx + 2'd1;
      end
   end

   assign w_last_strobe = r_we ? (r_cnt == WR_LAST) : (r_cnt == RD_LAST);

   // Main FSM: next state and all pad/bus outputs registered together.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_ack       <= 1'b0;
         r_rdata     <= '0;
         r_busy      <= 1'b0;
         r_cs_n      <= '1;
         r_read_n    <= 1'b1;
         r_write_n   <= 1'b1;
         r_sram_addr <= '0;
         r_sram_data <= '0;
         r_oe        <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_req) begin
                  r_waddr <= i_addr[20:2];
                  r_we    <= i_we;
                  r_wdata <= i_wdata;
                  r_be    <= i_be;
                  r_busy  <= 1'b1;
                  if (i_we && !w_first[2]) begin
                     // Nothing enabled: complete without touching the SRAM.
                     r_state <= ACK;
                     r_ack   <= 1'b1;
                  end else begin
                     r_state     <= SETUP;
                     r_idx       <= w_start_idx;
                     r_cs_n      <= cs_decode(i_addr[22:21]);
                     r_sram_addr <= {i_addr[20:2], w_start_idx};
                     if (i_we) begin
                        r_sram_data <= sel_byte(i_wdata, w_start_idx);
                        r_oe        <= 1'b1;
                     end
                  end
               end
            end

            SETUP: begin
               r_state <= STROBE;
               r_cnt   <= '0;
               if (r_we) r_write_n <= 1'b0;
               else      r_read_n  <= 1'b0;
            end

            STROBE: begin
               if (w_last_strobe) begin
                  r_state   <= HOLD;
                  r_read_n  <= 1'b1;
                  r_write_n <= 1'b1;
                  if (!r_we) r_rdata[{r_idx, 3'b000} +: SRAM_DW] <= i_sram_data;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            HOLD: begin
               if (w_more) begin
                  r_state     <= SETUP;
                  r_idx       <= w_next_idx;
                  r_sram_addr <= {r_waddr, w_next_idx};
                  if (r_we) r_sram_data <= sel_byte(r_wdata, w_next_idx);
               end else begin
                  r_state <= ACK;
                  r_ack   <= 1'b1;
                  r_cs_n  <= '1;
                  r_oe    <= 1'b0;
               end
            end

            ACK: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end

            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_ack          = r_ack;
   assign o_rdata        = r_rdata;
   assign o_busy         = r_busy;
   assign o_sram_cs_n    = r_cs_n;
   assign o_sram_read_n  = r_read_n;
   assign o_sram_write_n = r_write_n;
   assign o_sram_addr    = r_sram_addr;
   assign o_sram_data    = r_sram_data;
   assign o_sram_data_oe = r_oe;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: a behavioural SRAM bank, pin monitors
// that log every strobe, and a scoreboard of expected bus completions.
module tb_sram_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        we;
   logic [22:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        o_ack;
   logic [31:0] o_rdata;
   logic        o_busy;
   logic [3:0]  o_sram_cs_n;
   logic        o_sram_read_n;
   logic        o_sram_write_n;
   logic [20:0] o_sram_addr;
   logic [7:0]  o_sram_data;
   logic        o_sram_data_oe;
   logic [7:0]  sram_din = 8'h00;

   sram_ctrl #(.READ_WAIT(2), .WRITE_WAIT(2)) dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_req          (req),
      .i_we           (we),
      .i_addr         (addr),
      .i_wdata        (wdata),
      .i_be           (be),
      .o_ack          (o_ack),
      .o_rdata        (o_rdata),
      .o_busy         (o_busy),
      .o_sram_cs_n    (o_sram_cs_n),
      .o_sram_read_n  (o_sram_read_n),
      .o_sram_write_n (o_sram_write_n),
      .o_sram_addr    (o_sram_addr),
      .o_sram_data    (o_sram_data),
      .o_sram_data_oe (o_sram_data_oe),
      .i_sram_data    (sram_din)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [3:0]  cs;
      logic [20:0] a;
      logic [7:0]  d;
      int          len;
   } sev_t;

   typedef struct {
      logic        we;
      logic [31:0] rdata;
      int          lat;
   } exp_t;

   logic [7:0] mem [int];
   sev_t wr_obs[$];
   sev_t rd_obs[$];
   sev_t wr_exp[$];
   exp_t sb[$];

   int viol         = 0;
   int cs_active    = 0;
   int ack_cnt      = 0;
   int last_ack_cyc = 0;
   int setup_cyc    = 0;
   int rlen         = 0;
   int wlen         = 0;
   logic [3:0] prev_cs = 4'hF;
   sev_t rcur;
   sev_t wcur;

   function automatic int key(input logic [3:0] cs_n, input logic [20:0] a);
      int chip;
      chip = -1;
      for (int i = 0; i < 4; i++) if (cs_n[i] === 1'b0) chip = i;
      if (chip < 0) return -1;
      return chip * 32'h0020_0000 + int'(a);
   endfunction

   // SRAM bank model and pin monitor, sampled away from the active edge.
   always @(negedge clk) begin
      int k;
      if (!o_sram_read_n && !o_sram_write_n) viol++;
      if (o_sram_data_oe && !o_sram_read_n) viol++;
      if (o_sram_cs_n != 4'hF) cs_active++;
      if (o_ack) begin
         ack_cnt++;
         last_ack_cyc = cyc;
      end
      if (o_sram_cs_n != 4'hF && prev_cs == 4'hF) setup_cyc = cyc;
      prev_cs = o_sram_cs_n;

      if (o_sram_read_n === 1'b0) begin
         if (rlen == 0) rcur = '{o_sram_cs_n, o_sram_addr, 8'h00, 0};
         rlen++;
         k = key(o_sram_cs_n, o_sram_addr);
         sram_din = mem.exists(k) ? mem[k] : 8'h00;
      end else begin
         if (rlen != 0) begin
            rcur.len = rlen;
            rd_obs.push_back(rcur);
         end
         rlen = 0;
         sram_din = 8'h00;
      end

      if (o_sram_write_n === 1'b0) begin
         if (wlen == 0) wcur = '{o_sram_cs_n, o_sram_addr, o_sram_data, 0};
         wlen++;
         k = key(o_sram_cs_n, o_sram_addr);
         if (o_sram_data_oe && k >= 0) mem[k] = o_sram_data;
      end else begin
         if (wlen != 0) begin
            wcur.len = wlen;
            wr_obs.push_back(wcur);
         end
         wlen = 0;
      end
   end

   // Bus requester: called at a falling edge while the DUT is idle.
   task automatic xfer(input logic w, input logic [22:0] a, input logic [31:0] d,
                       input logic [3:0] b, output int lat, output logic [31:0] rd,
                       output bit to);
      int t0;
      to  = 1'b1;
      lat = -1;
      rd  = '0;
      req = 1'b1; we = w; addr = a; wdata = d; be = b;
      t0  = cyc;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (o_ack === 1'b1) begin
            lat = cyc - t0;
            rd  = o_rdata;
            to  = 1'b0;
            break;
         end
      end
      req = 1'b0;
      @(negedge clk);
   endtask

   task automatic clear_logs();
      rd_obs.delete();
      wr_obs.delete();
      wr_exp.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
      repeat (3) @(negedge clk);
      n_total++; if (o_sram_cs_n !== 4'hF) $display("FAIL reset_cs_n got %h want %h", o_sram_cs_n, 4'hF); else n_pass++;
      n_total++; if (o_sram_read_n !== 1'b1) $display("FAIL reset_read_n got %b want 1", o_sram_read_n); else n_pass++;
      n_total++; if (o_sram_write_n !== 1'b1) $display("FAIL reset_write_n got %b want 1", o_sram_write_n); else n_pass++;
      n_total++; if (o_sram_addr !== 21'h0) $display("FAIL reset_addr got %h want 0", o_sram_addr); else n_pass++;
      n_total++; if (o_sram_data !== 8'h0) $display("FAIL reset_data got %h want 0", o_sram_data); else n_pass++;
      n_total++; if (o_sram_data_oe !== 1'b0) $display("FAIL reset_oe got %b want 0", o_sram_data_oe); else n_pass++;
      n_total++; if (o_ack !== 1'b0) $display("FAIL reset_ack got %b want 0", o_ack); else n_pass++;
      n_total++; if (o_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", o_rdata); else n_pass++;
      n_total++; if (o_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", o_busy); else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      n_total++; if (o_busy !== 1'b0) $display("FAIL idle_busy got %b want 0", o_busy); else n_pass++;
   endtask

   task automatic test_read(input logic [22:0] a, input logic [3:0] cs_exp,
                            input logic [31:0] word);
      int lat; logic [31:0] rd; bit to; exp_t e;
      for (int i = 0; i < 4; i++) begin
         logic [7:0] bv;
         bv = word[i*8 +: 8];
         mem[key(cs_exp, {a[20:2], 2'(i)})] = bv;
      end
      clear_logs();
      sb.push_back('{1'b0, word, 17});
      xfer(1'b0, a, 32'h0, 4'h0, lat, rd, to);
      e = sb.pop_front();
      n_total++; if (to) $display("FAIL read_timeout addr %h no ack within bound", a); else n_pass++;
      n_total++; if (lat != e.lat) $display("FAIL read_latency got %0d want %0d", lat, e.lat); else n_pass++;
      n_total++; if (rd !== e.rdata) $display("FAIL read_rdata got %h want %h", rd, e.rdata); else n_pass++;
      n_total++; if (rd_obs.size() != 4) $display("FAIL read_strobes got %0d want 4", rd_obs.size()); else n_pass++;
      n_total++; if (wr_obs.size() != 0) $display("FAIL read_no_write got %0d want 0", wr_obs.size()); else n_pass++;
      for (int i = 0; i < rd_obs.size() && i < 4; i++) begin
         logic [20:0] ea;
         ea = {a[20:2], 2'(i)};
         n_total++; if (rd_obs[i].a !== ea) $display("FAIL read_addr%0d got %h want %h", i, rd_obs[i].a, ea); else n_pass++;
         n_total++; if (rd_obs[i].cs !== cs_exp) $display("FAIL read_cs%0d got %b want %b", i, rd_obs[i].cs, cs_exp); else n_pass++;
         n_total++; if (rd_obs[i].len != 2) $display("FAIL read_len%0d got %0d want 2", i, rd_obs[i].len); else n_pass++;
      end
   endtask

   task automatic test_write();
      int lat; logic [31:0] rd; bit to; exp_t e; sev_t x; sev_t o;
      clear_logs();
      wr_exp.push_back('{4'b0111, 21'h000010, 8'hDD, 2});
      wr_exp.push_back('{4'b0111, 21'h000012, 8'hBB, 2});
      sb.push_back('{1'b1, 32'h0, 9});
      xfer(1'b1, 23'h600010, 32'hAABBCCDD, 4'b0101, lat, rd, to);
      e = sb.pop_front();
      n_total++; if (to) $display("FAIL write_timeout no ack within bound"); else n_pass++;
      n_total++; if (lat != e.lat) $display("FAIL write_latency got %0d want %0d", lat, e.lat); else n_pass++;
      n_total++; if (wr_obs.size() != wr_exp.size()) $display("FAIL write_strobes got %0d want %0d", wr_obs.size(), wr_exp.size()); else n_pass++;
      n_total++; if (rd_obs.size() != 0) $display("FAIL write_no_read got %0d want 0", rd_obs.size()); else n_pass++;
      while (wr_exp.size() != 0 && wr_obs.size() != 0) begin
         x = wr_exp.pop_front();
         o = wr_obs.pop_front();
         n_total++; if (o.a !== x.a) $display("FAIL write_addr got %h want %h", o.a, x.a); else n_pass++;
         n_total++; if (o.d !== x.d) $display("FAIL write_data got %h want %h", o.d, x.d); else n_pass++;
         n_total++; if (o.cs !== x.cs) $display("FAIL write_cs got %b want %b", o.cs, x.cs); else n_pass++;
         n_total++; if (o.len != x.len) $display("FAIL write_len got %0d want %0d", o.len, x.len); else n_pass++;
      end
   endtask

   task automatic test_write_be0();
      int lat; logic [31:0] rd; bit to; exp_t e;
      clear_logs();
      cs_active = 0;
      sb.push_back('{1'b1, 32'h0, 1});
      xfer(1'b1, 23'h000100, 32'h12345678, 4'b0000, lat, rd, to);
      e = sb.pop_front();
      n_total++; if (to) $display("FAIL be0_timeout no ack within bound"); else n_pass++;
      n_total++; if (lat != e.lat) $display("FAIL be0_latency got %0d want %0d", lat, e.lat); else n_pass++;
      n_total++; if (cs_active != 0) $display("FAIL be0_cs_active got %0d want 0", cs_active); else n_pass++;
      n_total++; if (wr_obs.size() + rd_obs.size() != 0) $display("FAIL be0_strobes got %0d want 0", wr_obs.size() + rd_obs.size()); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int lat; logic [31:0] rd; bit to; exp_t e; int ack_w;
      clear_logs();
      sb.push_back('{1'b1, 32'h0, 17});
      sb.push_back('{1'b0, 32'hCAFEF00D, 17});
      xfer(1'b1, 23'h200020, 32'hCAFEF00D, 4'b1111, lat, rd, to);
      ack_w = last_ack_cyc;
      e = sb.pop_front();
      n_total++; if (to || lat != e.lat) $display("FAIL b2b_write_latency got %0d want %0d", lat, e.lat); else n_pass++;
      xfer(1'b0, 23'h200020, 32'h0, 4'h0, lat, rd, to);
      e = sb.pop_front();
      n_total++; if (to || lat != e.lat) $display("FAIL b2b_read_latency got %0d want %0d", lat, e.lat); else n_pass++;
      n_total++; if (rd !== e.rdata) $display("FAIL b2b_rdata got %h want %h", rd, e.rdata); else n_pass++;
      n_total++; if (setup_cyc - ack_w < 2) $display("FAIL b2b_idle_gap got %0d want >=2", setup_cyc - ack_w); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int cnt; int acks0;
      cnt = 0;
      req = 1'b1; we = 1'b0; addr = 23'h000004; be = 4'h0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (o_sram_read_n === 1'b0) cnt++;
         if (cnt == 2) break;
      end
      n_total++; if (cnt != 2) $display("FAIL rstmid_strobe got %0d strobe cycles want 2", cnt); else n_pass++;
      acks0 = ack_cnt;
      rst = 1'b1;
      req = 1'b0;
      @(negedge clk);
      n_total++; if (o_sram_read_n !== 1'b1) $display("FAIL rstmid_read_n got %b want 1", o_sram_read_n); else n_pass++;
      n_total++; if (o_sram_write_n !== 1'b1) $display("FAIL rstmid_write_n got %b want 1", o_sram_write_n); else n_pass++;
      n_total++; if (o_sram_cs_n !== 4'hF) $display("FAIL rstmid_cs_n got %h want %h", o_sram_cs_n, 4'hF); else n_pass++;
      n_total++; if (o_sram_data_oe !== 1'b0) $display("FAIL rstmid_oe got %b want 0", o_sram_data_oe); else n_pass++;
      n_total++; if (o_busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", o_busy); else n_pass++;
      rst = 1'b0;
      repeat (30) @(negedge clk);
      n_total++; if (ack_cnt != acks0) $display("FAIL rstmid_ack got %0d acks want 0", ack_cnt - acks0); else n_pass++;
      n_total++; if (o_busy !== 1'b0) $display("FAIL rstmid_idle_busy got %b want 0", o_busy); else n_pass++;
      clear_logs();
   endtask

   task automatic test_protocol();
      n_total++; if (viol != 0) $display("FAIL protocol_violations got %0d want 0", viol); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_read(23'h000004, 4'b1110, 32'h44332211);
      test_write();
      test_write_be0();
      test_back_to_back();
      test_read(23'h7FFFFC, 4'b0111, 32'hA4A3A2A1);
      test_reset_mid();
      test_protocol();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
Bus-side master for the external 2Mx8 asynchronous SRAM bank: 4 chips, each with 21 address bits and 8 data bits, sharing one read strobe and one write strobe. It converts single 32-bit word requests from the system bus into a sequence of byte accesses on the SRAM pins. It is the initiator of the SRAM interface and sits in top between the system bus and the io_sram_* pads. The bidirectional data pad is built in top from o_sram_data, o_sram_data_oe and i_sram_data.

Parameters:
READ_WAIT, 2, number of cycles o_sram_read_n is held low per byte; minimum 1.
WRITE_WAIT, 2, number of cycles o_sram_write_n is held low per byte; minimum 1.

Ports:
i_clk  input  1  system clock; single clock domain.
i_reset  input  1  synchronous reset, active-high.
i_req  input  1  request; held high until o_ack.
i_we  input  1  1 = write, 0 = read; valid while i_req is high.
i_addr  input  23  byte address; bits [1:0] ignored (word aligned).
i_wdata  input  32  write data, little-endian (byte0 = [7:0]).
i_be  input  4  byte enables for writes; ignored for reads.
o_ack  output  1  single-cycle completion pulse.
o_rdata  output  32  read data; valid while o_ack is high.
o_busy  output  1  high whenever the state is not IDLE.
o_sram_cs_n  output  4  active-low chip select, one-hot decode of i_addr[22:21].
o_sram_read_n  output  1  active-low read strobe.
o_sram_write_n  output  1  active-low write strobe.
o_sram_addr  output  21  byte address on the SRAM pins.
o_sram_data  output  8  write data to the pad.
o_sram_data_oe  output  1  pad output enable.
i_sram_data  input  8  read data from the pad.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (i_clk, i_reset).
- Reset values:
  - o_sram_cs_n = 4'hF, o_sram_read_n = 1, o_sram_write_n = 1.
  - o_sram_addr = 0, o_sram_data = 0, o_sram_data_oe = 0.
  - o_ack = 0, o_rdata = 0, o_busy = 0.
  - State is IDLE.
- All outputs are registered.
- FSM states: IDLE, SETUP, STROBE, HOLD, ACK.
- IDLE:
  - i_req is sampled only in this state.
  - On i_req = 1, latch the word address, i_we, i_wdata and i_be.
  - Byte index = 0 for reads; for writes, the lowest set bit of i_be.
  - Write with i_be = 0 → go to ACK directly, no SRAM cycle.
  - Otherwise → SETUP.
- SETUP (1 cycle):
  - o_sram_cs_n is driven low for the selected chip.
  - o_sram_addr = {addr[20:2], idx}.
  - Both strobes are high.
  - For writes, o_sram_data = the selected byte and o_sram_data_oe = 1.
- STROBE:
  - Read: o_sram_read_n low for READ_WAIT cycles; i_sram_data is captured into o_rdata byte idx on the last strobe cycle.
  - Write: o_sram_write_n low for WRITE_WAIT cycles.
- HOLD (1 cycle):
  - Strobes high; address, chip select and data unchanged.
  - Then: reads go to SETUP with idx+1 until idx = 3.
  - Writes go to SETUP with the next enabled byte above idx; if none remains → ACK.
- ACK (1 cycle):
  - o_ack = 1; o_sram_cs_n = 4'hF; o_sram_data_oe = 0.
  - → IDLE. i_req is ignored in this cycle.
- The requester deasserts i_req after the clock edge where it sees o_ack = 1. A new request is accepted from the next IDLE cycle.
- Read latency: request accepted at cycle T (IDLE, i_req = 1); o_ack at T + 1 + 4·(READ_WAIT + 2). With defaults that is T+17.
- Write latency: T + 1 + n·(WRITE_WAIT + 2), where n = popcount(i_be). For i_be = 0 it is T+1.
- o_rdata bytes keep their previous value until overwritten by a capture. For reads all four bytes are overwritten.
- Read and write strobes are never low in the same cycle.
- o_sram_data_oe is never 1 during a read.
- Reset asserted mid-operation: all outputs take their reset values on the next edge, no o_ack is issued, and the pending request is dropped.
- Top-address wrap: addr 0x7FFFFC selects cs_n = 4'b0111 and o_sram_addr 0x1FFFFC..0x1FFFFF. No carry across chips.

Decomposition:
- Shared package sram_ctrl_pkg holds:
  - state encoding (IDLE = 0, SETUP = 1, STROBE = 2, HOLD = 3, ACK = 4) and its width;
  - SRAM_AW = 21, SRAM_DW = 8, SRAM_CHIPS = 4.
- No sub-module: the chip-select decode and byte sequencer are small and stay inline.

Test Plan:
- Reset: assert i_reset for 3 cycles during idle → all outputs at their reset values, o_busy = 0.
- Read at 0x000004, SRAM model returns 0x11, 0x22, 0x33, 0x44 at byte addresses 4..7 → o_sram_addr steps 0x4..0x7, cs_n = 4'b1110, o_rdata = 0x44332211 with o_ack at T+17.
- Write at 0x600010, wdata 0xAABBCCDD, be = 4'b0101 → cs_n = 4'b0111 during access and exactly 2 write strobes, 2 cycles each:
  - addr 0x000010 data 0xDD;
  - addr 0x000012 data 0xBB;
  - o_ack at T+9.
- Write with be = 4'b0000 → o_ack at T+1, strobes and cs_n never change.
- Back-to-back: write then read at the same address → read returns the written bytes; there is at least one IDLE cycle between o_ack and the next SETUP.
- Reset on the second STROBE cycle of a read → strobes, cs_n and oe return to reset values on the next edge; no o_ack ever appears.
